// File: rtl/arb_mux_4_1.sv
// Four-channel round-robin arbiter feeding a single registered output stage.
// One word moves per cycle when downstream is ready; the pointer rotates past each winner.
module arb_mux_4_1 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       sel,
    input  logic             out_ready
);

    logic [1:0]       r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_sel;

    logic [1:0]       w_grant;
    logic [3:0]       w_dec;
    logic             w_load;
    logic [WIDTH-1:0] w_mux;

    // Scan from the farthest candidate back to ptr so the nearest requester wins.
    always_comb begin
        w_grant = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (in_valid[r_ptr + 2'(k)]) begin
                w_grant = r_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        w_dec  = 4'b0001 << w_grant;
        w_load = (|in_valid) & (~r_out_valid | out_ready) & ~rst;
        w_mux  = ({WIDTH{w_dec[0]}} & d0)
               | ({WIDTH{w_dec[1]}} & d1)
               | ({WIDTH{w_dec[2]}} & d2)
               | ({WIDTH{w_dec[3]}} & d3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sel       <= 2'd0;
        end else if (w_load) begin
            r_ptr       <= w_grant + 2'd1;
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux;
            r_sel       <= w_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_load ? w_dec : 4'b0000;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sel       = r_sel;

endmodule

// File: tb/tb_arb_mux_4_1.sv
// Randomized and directed bench for arb_mux_4_1 against a round-robin reference model.
module tb_arb_mux_4_1;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [3:0]       in_valid;
    logic [WIDTH-1:0] d [4];
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       sel;
    logic             out_ready;

    int n_cmp;
    int n_err;

    // Reference model state
    int m_ptr;
    int m_valid;
    int m_data;
    int m_sel;

    arb_mux_4_1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .d0        (d[0]),
        .d1        (d[1]),
        .d2        (d[2]),
        .d3        (d[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_grant(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_data  = 0;
        m_sel   = 0;
    endtask

    // Inputs are already set; check in_ready, clock once, then check registered outputs.
    task automatic step();
        int g;
        int load;
        logic [3:0] exp_rdy;
        #1;
        g    = m_grant(in_valid, m_ptr);
        load = (g >= 0 && (m_valid == 0 || out_ready == 1'b1)) ? 1 : 0;
        exp_rdy = 4'b0000;
        if (load == 1) exp_rdy[g] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (load == 1) begin
            m_data  = 32'(d[g]);
            m_sel   = g;
            m_valid = 1;
            m_ptr   = (g + 1) % 4;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
        check("out_valid", 32'(out_valid), m_valid);
        check("out_data", 32'(out_data), m_data);
        check("sel", 32'(sel), m_sel);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_reset();

        // Reset with every channel requesting
        rst       = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = WIDTH'(i + 1);
        #12;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_sel", 32'(sel), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("first_sel", 32'(sel), 0);
        check("first_data", 32'(out_data), 1);

        // Full rotation with all channels valid
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_out_valid", 32'(out_valid), 1);
        end

        // Backpressure while channel 2's word 5 is held
        in_valid = 4'b0100;
        d[2]     = WIDTH'(5);
        step();
        check("bp_load_data", 32'(out_data), 5);
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_data", 32'(out_data), 5);
            check("bp_sel", 32'(sel), 2);
        end
        out_ready = 1'b1;

        // Only channel 2 requesting, leaves ptr at 3
        in_valid = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            d[2] = WIDTH'($urandom);
            step();
            check("ch2_sel", 32'(sel), 2);
        end

        // ptr=3, channels 1 and 3: grant 3 then wrap to 1
        in_valid = 4'b1010;
        step();
        check("wrap_first", 32'(sel), 3);
        step();
        check("wrap_second", 32'(sel), 1);

        // Async reset mid-cycle while holding a word
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 0);
        check("async_in_ready", 32'(in_ready), 0);
        m_reset();
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        check("post_rst_sel", 32'(sel), 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < 4; j++) d[j] = WIDTH'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arb_mux_4_1.md
ARB_MUX_4_1 -- requirements
Module: arb_mux_4_1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data width of each input channel and of the output.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 4 bits; bit i set means channel i offers data.
REQ-005 The block SHALL have ports d0, d1, d2, d3, input, WIDTH bits each, carrying channel 0-3 data.
REQ-006 The block SHALL have port in_ready, output, 4 bits; bit i set means channel i data is taken this cycle.
REQ-007 The block SHALL have port out_valid, output, 1 bit; the output register holds a word.
REQ-008 The block SHALL have port out_data, output, WIDTH bits, the registered selected word.
REQ-009 The block SHALL have port sel, output, 2 bits, the index of the channel whose word is in out_data.
REQ-010 The block SHALL have port out_ready, input, 1 bit; downstream accepts out_data this cycle.

Function
REQ-011 The block SHALL define an output transfer as out_valid & out_ready on a rising clk edge.
REQ-012 The block SHALL define an input transfer on channel i as in_valid[i] & in_ready[i] on a rising clk edge.
REQ-013 The block SHALL compute load = (|in_valid) & (~out_valid | out_ready) & ~rst combinationally.
REQ-014 The block SHALL keep a 2-bit round-robin pointer ptr that gives the highest-priority channel.
REQ-015 The block SHALL compute grant as the first i with in_valid[i] set, scanning ptr, ptr+1, ptr+2, ptr+3, each modulo 4.
REQ-016 The block SHALL drive in_ready one-hot at bit grant when load=1, and all-zero otherwise.
REQ-017 in_ready SHALL depend on in_valid, out_valid, out_ready and ptr only; in_valid SHALL never be required to depend on in_ready.
REQ-018 On a load edge, the block SHALL set out_data to the granted channel's word, sel to grant, out_valid to 1 and ptr to (grant+1) mod 4.
REQ-019 On an edge with an output transfer and no load, the block SHALL clear out_valid; out_data, sel and ptr SHALL hold.
REQ-020 On an edge with out_valid=1 and out_ready=0, the block SHALL hold out_valid, out_data, sel and ptr, with in_ready=0.
REQ-021 Simultaneous output transfer and load SHALL replace the word in the same edge, giving one transfer per cycle sustained.
REQ-022 Latency from an input transfer to out_valid SHALL be exactly 1 cycle.
REQ-023 The block SHALL NOT drop or duplicate any word.
REQ-024 With in_valid=0 the block SHALL leave ptr unchanged.
REQ-025 ptr SHALL wrap from 3 to 0.
REQ-026 A single persistently requesting channel SHALL be granted every cycle that load=1.
REQ-027 Out of every 4 consecutive loads with all 4 channels requesting, the block SHALL grant each channel exactly once.
REQ-028 The block SHALL select data using AND-OR gating with decoded grant, one term per channel, replicated to WIDTH bits.

Reset
REQ-029 While rst=1, regardless of clk, the block SHALL force out_valid=0, out_data=0, sel=0, ptr=0 and in_ready=0.
REQ-030 Reset asserted mid-transfer SHALL discard the held word with no output transfer.
REQ-031 The first edge after rst deasserts SHALL behave as a normal edge with ptr=0.

Verification
REQ-032 The bench SHALL cover reset with all in_valid=1: in_ready=0 and out_valid=0 during reset; on the first edge channel 0 is granted, out_data=d0, sel=0.
REQ-033 The bench SHALL cover all channels valid with d0..d3=1,2,3,4 and out_ready=1 for 8 cycles: sel sequence 0,1,2,3,0,1,2,3 and out_data 1,2,3,4,1,2,3,4, with out_valid continuously 1.
REQ-034 The bench SHALL cover backpressure with out_ready=0 for 3 cycles while holding word 5 from channel 2: out_data=5, sel=2 are stable, and in_ready=0.
REQ-035 The bench SHALL cover ptr=3 with only channels 1 and 3 valid: channel 3 is granted, then channel 1 (wrap-around).
REQ-036 The bench SHALL cover only channel 2 valid every cycle with out_ready=1: in_ready=4'b0100 every cycle and sel=2 throughout.
REQ-037 The bench SHALL cover rst asserted asynchronously mid-cycle while out_valid=1: out_valid drops before the next edge, and after release ptr=0.
